// File: rtl/pgm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pgm_pkg (package)
//  Description : Shared constants, FSM state encoding and helper functions
//                for the programmable packet scheduler read stage.
//                - STREAM_NUM  : number of scheduled streams
//                - STREAM_BASE : RAM address stride between stream buffers
//                - sch_state_t : scheduler FSM states
//                - stream_base : stream index -> RAM base address
//                - rr_pick     : round-robin arbiter starting after last winner
//  Revision    : 1.0 - initial release
// ============================================================================
package pgm_pkg;

   localparam int STREAM_NUM  = 4;
   localparam int SEL_W       = $clog2(STREAM_NUM);
   localparam int ADDR_W      = 10;
   localparam int STREAM_BASE = 128;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_GAP  = 2'd2
   } sch_state_t;

   // Base address of stream 'sel' in the packet RAM.
   function automatic logic [ADDR_W-1:0] stream_base(input logic [SEL_W-1:0] sel);
      return ADDR_W'(sel) * ADDR_W'(STREAM_BASE);
   endfunction

   // Round-robin pick: the first requester found walking upward from
   // last+1 (wrapping) wins. The scan runs from the farthest candidate to
   // the nearest so the nearest one overwrites the result last. The
   // previous winner itself (offset STREAM_NUM, which wraps to offset 0)
   // has the lowest priority. Relies on STREAM_NUM being a power of two.
   function automatic logic [SEL_W-1:0] rr_pick(
      input logic [STREAM_NUM-1:0] req,
      input logic [SEL_W-1:0]      last
   );
      logic [SEL_W-1:0] pick;
      logic [SEL_W-1:0] idx;
      pick = last;
      for (int i = STREAM_NUM; i >= 1; i--) begin
         idx = last + SEL_W'(i);
         if (req[idx]) begin
            pick = idx;
         end
      end
      return pick;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pgm_sch_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pgm_sch_timer
//  Description : One stream's interval down-counter with pending flag and
//                miss detection. The counter expires when it reads 0 while
//                running; on expiry it reloads to (ivl-1), with ivl = 0
//                treated as 1 (expiry every running cycle).
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                cfg_reset       - reload counter, clear pending
//                run             - counter decrements while high
//                ivl             - interval in cycles
//                issue           - scheduler is issuing this stream now
//                exhausted       - packet budget used up; drop pending
//                pending         - stream wants a packet slot
//                miss            - expiry found pending already set
//  Revision    : 1.0 - initial release
// ============================================================================
module pgm_sch_timer #(
   parameter int IVL_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_reset,
   input  logic             run,
   input  logic [IVL_W-1:0] ivl,
   input  logic             issue,
   input  logic             exhausted,
   output logic             pending,
   output logic             miss
);

   logic [IVL_W-1:0] r_cnt;
   logic             r_pending;
   logic [IVL_W-1:0] w_reload;
   logic             w_expire;

   assign w_reload = (ivl == '0) ? '0 : (ivl - IVL_W'(1));
   assign w_expire = run & (r_cnt == '0);

   // An expiry that coincides with this stream's own issue is absorbed by
   // keeping pending set, so it is not a miss.
   assign miss    = w_expire & r_pending & ~issue;
   assign pending = r_pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_pending <= 1'b0;
      end else if (cfg_reset) begin
         r_cnt     <= w_reload;
         r_pending <= 1'b0;
      end else begin
         if (w_expire) begin
            r_cnt <= w_reload;
         end else if (run) begin
            r_cnt <= r_cnt - IVL_W'(1);
         end

         // Expiry wins over issue so a same-cycle expiry keeps pending set.
         // A stream that has hit its budget is never pending again.
         if (exhausted) begin
            r_pending <= 1'b0;
         end else if (w_expire) begin
            r_pending <= 1'b1;
         end else if (issue) begin
            r_pending <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pgm_sch_rd.sv
`default_nettype none
// ============================================================================
//  Module      : pgm_sch_rd
//  Description : Programmable packet scheduler, read side. Per-stream
//                interval timers raise pending requests; a round-robin
//                arbiter issues one packet at a time to the send stage and
//                waits for its end-of-packet pulse (with a watchdog) before
//                a one-cycle gap and the next issue.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                pgm_config_reset     - clear statistics and scheduling state
//                pgm_sch_en           - global scheduling enable
//                stream_en[3:0]       - per-stream enable
//                stream_ivl_0..3      - cycles between packet starts
//                stream_limit_0..3    - packet budget per stream, 0=unlimited
//                in_pgm_data_ready    - downstream ready
//                pkt_done             - end-of-packet pulse from send stage
//                sent_pkt_addr[9:0]   - RAM base address of active stream
//                sent_pkt_rd          - one-cycle packet start pulse
//                sch_busy             - packet in flight
//                sch_done             - all enabled budgets exhausted
//                sch_miss_cnt[31:0]   - expiries that found stream pending
//                sch_wd_err           - sticky watchdog error
//  Revision    : 1.0 - initial release
// ============================================================================
module pgm_sch_rd #(
   parameter int STREAM_NUM = 4,
   parameter int IVL_W      = 32,
   parameter int WD_MAX     = 1023
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pgm_config_reset,
   input  logic             pgm_sch_en,
   input  logic [3:0]       stream_en,
   input  logic [IVL_W-1:0] stream_ivl_0,
   input  logic [IVL_W-1:0] stream_ivl_1,
   input  logic [IVL_W-1:0] stream_ivl_2,
   input  logic [IVL_W-1:0] stream_ivl_3,
   input  logic [31:0]      stream_limit_0,
   input  logic [31:0]      stream_limit_1,
   input  logic [31:0]      stream_limit_2,
   input  logic [31:0]      stream_limit_3,
   input  logic             in_pgm_data_ready,
   input  logic             pkt_done,
   output logic [9:0]       sent_pkt_addr,
   output logic             sent_pkt_rd,
   output logic             sch_busy,
   output logic             sch_done,
   output logic [31:0]      sch_miss_cnt,
   output logic             sch_wd_err
);

   import pgm_pkg::*;

   localparam int                WD_W    = $clog2(WD_MAX + 1);
   localparam logic [WD_W-1:0]   WD_LAST = WD_W'(WD_MAX - 1);

   // ------------------------------------------------------------------
   // Per-stream configuration gathered into arrays
   // ------------------------------------------------------------------
   logic [IVL_W-1:0] w_ivl   [STREAM_NUM];
   logic [31:0]      w_limit [STREAM_NUM];

   assign w_ivl[0]   = stream_ivl_0;
   assign w_ivl[1]   = stream_ivl_1;
   assign w_ivl[2]   = stream_ivl_2;
   assign w_ivl[3]   = stream_ivl_3;
   assign w_limit[0] = stream_limit_0;
   assign w_limit[1] = stream_limit_1;
   assign w_limit[2] = stream_limit_2;
   assign w_limit[3] = stream_limit_3;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   sch_state_t       r_state;
   logic [9:0]       r_addr;
   logic             r_rd;
   logic             r_busy;
   logic             r_done;
   logic [31:0]      r_miss_cnt;
   logic             r_wd_err;
   logic [WD_W-1:0]  r_wd_cnt;
   logic [SEL_W-1:0] r_last;
   logic [31:0]      r_issue_cnt [STREAM_NUM];

   logic [STREAM_NUM-1:0] w_exhausted;
   logic [STREAM_NUM-1:0] w_run;
   logic [STREAM_NUM-1:0] w_pending;
   logic [STREAM_NUM-1:0] w_miss;
   logic [STREAM_NUM-1:0] w_issue_vec;
   logic [STREAM_NUM-1:0] w_eligible;
   logic [SEL_W-1:0]      w_winner;
   logic                  w_issue;
   logic [31:0]           w_miss_next;
   logic                  w_done_next;

   // ------------------------------------------------------------------
   // Per-stream timers
   // ------------------------------------------------------------------
   for (genvar n = 0; n < STREAM_NUM; n++) begin : g_stream
      assign w_exhausted[n] = (w_limit[n] != 32'd0) && (r_issue_cnt[n] >= w_limit[n]);
      assign w_run[n]       = pgm_sch_en & stream_en[n] & ~w_exhausted[n];
      assign w_issue_vec[n] = w_issue & (w_winner == SEL_W'(n));

      pgm_sch_timer #(
         .IVL_W (IVL_W)
      ) u_timer (
         .clk       (clk),
         .rst       (rst),
         .cfg_reset (pgm_config_reset),
         .run       (w_run[n]),
         .ivl       (w_ivl[n]),
         .issue     (w_issue_vec[n]),
         .exhausted (w_exhausted[n]),
         .pending   (w_pending[n]),
         .miss      (w_miss[n])
      );
   end

   // A stream whose enable has been dropped keeps its pending flag but is
   // not served until it is enabled again.
   assign w_eligible = w_pending & ~w_exhausted & stream_en;
   assign w_winner   = rr_pick(w_eligible, r_last);

   // No issue in the cycle the configuration is being cleared, so the
   // issue counts never miss a packet that went out.
   assign w_issue = (r_state == ST_IDLE) & pgm_sch_en & in_pgm_data_ready &
                    (|w_eligible) & ~pgm_config_reset;

   // ------------------------------------------------------------------
   // Statistics next-state
   // ------------------------------------------------------------------
   always_comb begin
      logic [32:0] sum;
      sum = {1'b0, r_miss_cnt};
      for (int i = 0; i < STREAM_NUM; i++) begin
         sum = sum + 33'(w_miss[i]);
      end
      w_miss_next = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   end

   always_comb begin
      w_done_next = |stream_en;
      for (int i = 0; i < STREAM_NUM; i++) begin
         if (stream_en[i] && !w_exhausted[i]) begin
            w_done_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_miss_cnt <= '0;
         r_done     <= 1'b0;
         for (int i = 0; i < STREAM_NUM; i++) begin
            r_issue_cnt[i] <= '0;
         end
      end else begin
         r_done <= w_done_next;
         if (pgm_config_reset) begin
            r_miss_cnt <= '0;
            for (int i = 0; i < STREAM_NUM; i++) begin
               r_issue_cnt[i] <= '0;
            end
         end else begin
            r_miss_cnt <= w_miss_next;
            for (int i = 0; i < STREAM_NUM; i++) begin
               if (w_issue_vec[i]) begin
                  r_issue_cnt[i] <= r_issue_cnt[i] + 32'd1;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Scheduler FSM. Outputs are registered; sent_pkt_addr holds from issue
   // until the next issue because downstream counters sample it late.
   // WAIT lasts at most WD_MAX cycles before the watchdog forces GAP.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_addr   <= '0;
         r_rd     <= 1'b0;
         r_busy   <= 1'b0;
         r_wd_cnt <= '0;
         r_wd_err <= 1'b0;
         r_last   <= SEL_W'(STREAM_NUM - 1);
      end else begin
         r_rd <= 1'b0;
         if (pgm_config_reset) begin
            r_wd_err <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_issue) begin
                  r_addr   <= stream_base(w_winner);
                  r_rd     <= 1'b1;
                  r_busy   <= 1'b1;
                  r_last   <= w_winner;
                  r_wd_cnt <= '0;
                  r_state  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (pkt_done) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_GAP;
               end else if (r_wd_cnt == WD_LAST) begin
                  r_wd_err <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= ST_GAP;
               end else begin
                  r_wd_cnt <= r_wd_cnt + WD_W'(1);
               end
            end
            ST_GAP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign sent_pkt_addr = r_addr;
   assign sent_pkt_rd   = r_rd;
   assign sch_busy      = r_busy;
   assign sch_done      = r_done;
   assign sch_miss_cnt  = r_miss_cnt;
   assign sch_wd_err    = r_wd_err;

endmodule
`default_nettype wire

// File: doc/pgm_sch_rd.md
PGM_SCH_RD -- requirements
Module: pgm_sch_rd

Interface
REQ-001 SHALL have parameter STREAM_NUM, default 4: number of streams.
REQ-002 SHALL have parameter IVL_W, default 32: interval width.
REQ-003 SHALL have parameter WD_MAX, default 1023: watchdog limit in cycles.
REQ-004 SHALL have port clk, in, 1: sole clock.
REQ-005 SHALL have port rst, in, 1: reset, synchronous and active-high.
REQ-006 SHALL have port pgm_config_reset, in, 1: clears the statistics and scheduling state.
REQ-007 SHALL have port pgm_sch_en, in, 1: global scheduling enable.
REQ-008 SHALL have port stream_en, in, 4: per-stream enable.
REQ-009 SHALL have ports stream_ivl_0..3, in, IVL_W each: cycles between packet starts of each stream.
REQ-010 SHALL have ports stream_limit_0..3, in, 32 each: packet budget per stream; 0 = unlimited.
REQ-011 SHALL have port in_pgm_data_ready, in, 1: downstream ready.
REQ-012 SHALL have port pkt_done, in, 1: end-of-packet pulse from the send stage (its valid-write strobe).
REQ-013 SHALL have port sent_pkt_addr, out, 10: RAM base address of the active stream.
REQ-014 SHALL have port sent_pkt_rd, out, 1: one-cycle start pulse.
REQ-015 SHALL have port sch_busy, out, 1: high while a packet is in flight.
REQ-016 SHALL have port sch_done, out, 1: all budgets exhausted.
REQ-017 SHALL have port sch_miss_cnt, out, 32: count of interval expiries that found the stream already pending.
REQ-018 SHALL have port sch_wd_err, out, 1: sticky watchdog error flag.

Function
REQ-019 Stream n base address SHALL be n*128 (0, 128, 256, 384).
REQ-020 Each stream SHALL have an interval down-counter that decrements every cycle while pgm_sch_en & stream_en[n] & budget not exhausted.
REQ-021 On reaching 0, the interval counter SHALL set pending[n] and reload to stream_ivl_n-1 in the same cycle.
REQ-022 An interval value of 0 SHALL be treated as 1, i.e. expiry every cycle.
REQ-023 Expiry while pending[n] is already set SHALL increment sch_miss_cnt, saturating at 2^32-1; pending[n] stays set.
REQ-024 The FSM SHALL have states IDLE, WAIT, GAP.
REQ-025 IDLE SHALL issue when pgm_sch_en & in_pgm_data_ready & |pending.
REQ-026 On issue: choose the winner by round-robin starting after the last winner, drive sent_pkt_addr <= base, pulse sent_pkt_rd for exactly 1 cycle, clear pending[winner], increment the issue count of the winner, and go to WAIT.
REQ-027 WAIT SHALL hold sent_pkt_addr and assert sch_busy, and SHALL go to GAP on pkt_done.
REQ-028 WAIT SHALL count cycles; on reaching WD_MAX with no pkt_done it SHALL set sch_wd_err and go to GAP.
REQ-029 GAP SHALL last exactly 1 cycle and then return to IDLE.
REQ-030 Minimum spacing between sent_pkt_rd pulses SHALL be 3 cycles after pkt_done.
REQ-031 sent_pkt_addr SHALL hold its value after GAP until the next issue, because downstream counters sample it.
REQ-032 pkt_done arriving in IDLE or GAP SHALL be ignored.
REQ-033 Issue latency SHALL be 1 cycle: pending set in cycle t with ready high gives sent_pkt_rd in cycle t+1.
REQ-034 When the issue count of a stream equals stream_limit_n (non-zero), that stream SHALL stop its counter and never become pending again.
REQ-035 sch_done SHALL be 1 when every enabled stream has a non-zero limit that has been reached; it SHALL be 0 when no stream is enabled.
REQ-036 Deasserting pgm_sch_en SHALL freeze the interval counters and block new issues; an in-flight packet SHALL complete normally.
REQ-037 pgm_config_reset SHALL clear pending, issue counts, sch_miss_cnt and sch_wd_err, and SHALL reload the interval counters.
REQ-038 pgm_config_reset SHALL NOT abort WAIT; the FSM completes the in-flight packet.
REQ-039 If an expiry and an issue of the same stream occur in the same cycle, pending SHALL remain set and no miss SHALL be counted.

Reset
REQ-040 On rst: FSM = IDLE, sent_pkt_addr = 0, sent_pkt_rd = 0, sch_busy = 0, sch_done = 0, sch_miss_cnt = 0, sch_wd_err = 0, pending = 0, round-robin pointer = stream 3 (so stream 0 wins first), interval counters = 0.
REQ-041 Reset SHALL override every other input, including mid-WAIT.

Structure
REQ-042 Package pgm_pkg SHALL hold STREAM_NUM, the stream base-address constant (128), and the FSM state encodings.
REQ-043 The sub-module pgm_sch_timer (one interval counter + expiry/miss logic) SHALL be instantiated STREAM_NUM times.

Verification
REQ-044 Single stream: stream_en=0001, ivl_0=10, ready=1, pkt_done 6 cycles after each rd -> rd pulses every 10 cycles, addr=0, miss=0.
REQ-045 Round-robin: all streams enabled, ivl=1, pkt_done 4 cycles after rd -> issue order 0,128,256,384,0; sch_miss_cnt increments.
REQ-046 Budget: stream_en=0010, limit_1=3, ivl_1=20 -> exactly 3 rd pulses at addr=128, then sch_done=1.
REQ-047 Backpressure/watchdog: ready=0 for 50 cycles -> no rd; then ready=1 with pkt_done withheld -> sch_wd_err=1 after 1023 WAIT cycles, FSM returns to IDLE.
REQ-048 Mid-op events: pgm_config_reset pulsed during WAIT -> the in-flight packet completes, counters read 0. rst asserted during WAIT -> all outputs read their reset values on the next cycle.
